power_switch_ack_model: RTL and testbench
=========================================

POWER_SWITCH_ACK_MODEL -- requirements
Module: power_switch_ack_model

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent power-switch channels, legal range 1..32.
REQ-002 Parameter LAT_W, default 8: width of the latency operands and of each channel down-counter.
REQ-003 Parameter RESET_ACK, default all-ones (NUM_CH bits): per-channel value of ack_o during and after reset.
REQ-004 clk_i  input  1  clock.
REQ-005 rst_ni  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 switch_i  input  NUM_CH  power-switch request per channel, 1 = power on.
REQ-007 on_lat_i  input  LAT_W  extra cycles for an off-to-on transition, sampled at transition start.
REQ-008 off_lat_i  input  LAT_W  extra cycles for an on-to-off transition, sampled at transition start.
REQ-009 fault_i  input  NUM_CH  per-channel stuck-switch fault request, 1 = freeze channel.
REQ-010 ack_o  output  NUM_CH  emulated switch-cell acknowledge, registered.
REQ-011 busy_o  output  NUM_CH  channel is ramping, registered.

Function
REQ-012 Each channel SHALL be an independent two-state FSM, STABLE and RAMP, with a LAT_W-bit counter cnt and a 1-bit target register.
REQ-013 STABLE with switch_i==ack_o: SHALL hold all state.
REQ-014 STABLE with switch_i!=ack_o at a rising edge: SHALL go to RAMP, target<=switch_i, cnt<=on_lat_i if switch_i=1 else off_lat_i, busy_o<=1.
REQ-015 RAMP with switch_i==target and cnt!=0: SHALL decrement cnt by 1.
REQ-016 RAMP with switch_i==target and cnt==0: SHALL set ack_o<=target, busy_o<=0, go to STABLE.
REQ-017 Latency: a switch_i change sampled at edge k SHALL appear on ack_o after edge k+L+1, where L is the latency sampled at edge k; L=0 gives 1 cycle, L=2^LAT_W-1 gives 2^LAT_W cycles.
REQ-018 RAMP with switch_i!=target and switch_i==ack_o (request withdrawn): SHALL abort to STABLE, busy_o<=0, ack_o unchanged (no glitch).
REQ-019 RAMP with switch_i!=target and switch_i!=ack_o cannot occur for 1-bit channels; no extra handling SHALL exist.
REQ-020 Changes of on_lat_i/off_lat_i during RAMP SHALL NOT affect the in-flight count.
REQ-021 cnt SHALL never wrap: it decrements only when non-zero.
REQ-022 Channels SHALL NOT interact; simultaneous transitions on all channels SHALL each complete with their own latency.

Reset
REQ-023 While rst_ni=0: ack_o=RESET_ACK, busy_o=0, all FSMs STABLE, cnt=0, target=RESET_ACK, asynchronously.
REQ-024 Reset asserted mid-RAMP SHALL discard the transition; after release a channel whose switch_i differs from RESET_ACK SHALL start a fresh transition at the first rising edge.

Configuration
REQ-025 Macro POWER_SWITCH_FAULT_INJ_EN defined: fault_i[c]=1 SHALL freeze channel c (state, cnt, target, ack_o, busy_o held) from the next edge; on deassertion the channel SHALL resume from the frozen state, including a pending RAMP.
REQ-026 Macro undefined: fault_i SHALL be ignored (port present, no logic), and the channel SHALL behave per REQ-012..REQ-022.

Verification
REQ-027 Reset, NUM_CH=4, RESET_ACK=4'b1111, switch_i=4'b1111 -> ack_o=4'b1111, busy_o=0 for 20 cycles.
REQ-028 off_lat_i=15, switch_i[0] 1->0 at edge 10 -> busy_o[0]=1 from edge 10, ack_o[0]=0 after edge 26, other channels unchanged.
REQ-029 on_lat_i=0, off_lat_i=255, channel 1 off then on -> ack_o[1] falls 256 cycles after request, rises 1 cycle after next request.
REQ-030 off_lat_i=10, switch_i[2] 1->0 then back to 1 four cycles later -> ack_o[2] stays 1 throughout, busy_o[2] clears at the withdrawing edge.
REQ-031 All channels toggle at one edge with on_lat_i=3, off_lat_i=7 -> each ack_o bit changes 4 or 8 cycles later according to direction.
REQ-032 rst_ni pulsed low mid-RAMP on channel 3 -> ack_o[3]=1 immediately; with POWER_SWITCH_FAULT_INJ_EN, fault_i[3] held 5 cycles mid-RAMP extends ack latency by exactly 5 cycles.

Source files
------------

// File: rtl/power_switch_ack_model.sv
// Behavioural model of a bank of power-switch cells: each channel acknowledges a request after a programmable latency.
// Build option POWER_SWITCH_FAULT_INJ_EN enables per-channel freezing via fault_i.
//
// state     | meaning
// ST_STABLE | ack_o settled; waiting for switch_i to differ from ack_o
// ST_RAMP   | transition in flight; cnt counts down to the ack update
module power_switch_ack_model #(
  parameter int unsigned       NUM_CH    = 4,
  parameter int unsigned       LAT_W     = 8,
  parameter logic [NUM_CH-1:0] RESET_ACK = {NUM_CH{1'b1}}
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] switch_i,
  input  logic [LAT_W-1:0]  on_lat_i,
  input  logic [LAT_W-1:0]  off_lat_i,
  input  logic [NUM_CH-1:0] fault_i,
  output logic [NUM_CH-1:0] ack_o,
  output logic [NUM_CH-1:0] busy_o
);

  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_RAMP   = 1'b1;

  logic [NUM_CH-1:0] state_q, state_d;
  logic [NUM_CH-1:0] target_q, target_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [NUM_CH-1:0] busy_q, busy_d;
  logic [NUM_CH-1:0] freeze;
  logic [LAT_W-1:0]  cnt_q [NUM_CH];
  logic [LAT_W-1:0]  cnt_d [NUM_CH];

`ifdef POWER_SWITCH_FAULT_INJ_EN
  assign freeze = fault_i;
`else
  logic unused_fault;
  assign freeze       = '0;
  assign unused_fault = ^fault_i;
`endif

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    ack_d    = ack_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!freeze[c]) begin
        if (state_q[c] == ST_STABLE) begin
          if (switch_i[c] != ack_q[c]) begin
            state_d[c]  = ST_RAMP;
            target_d[c] = switch_i[c];
            cnt_d[c]    = switch_i[c] ? on_lat_i : off_lat_i;
            busy_d[c]   = 1'b1;
          end
        end else begin
          if (switch_i[c] == target_q[c]) begin
            if (cnt_q[c] != '0) begin
              cnt_d[c] = cnt_q[c] - LAT_W'(1);
            end else begin
              ack_d[c]   = target_q[c];
              busy_d[c]  = 1'b0;
              state_d[c] = ST_STABLE;
            end
          end else begin
            // Request withdrawn: switch_i is back at ack_o, so drop the ramp without touching ack.
            busy_d[c]  = 1'b0;
            state_d[c] = ST_STABLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= {NUM_CH{ST_STABLE}};
      target_q <= RESET_ACK;
      ack_q    <= RESET_ACK;
      busy_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign ack_o  = ack_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_power_switch_ack_model.sv
// Directed bench for power_switch_ack_model: expectations are queued with the edge they are due at
// and compared by a monitor on the falling clock edge.
module tb_power_switch_ack_model;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic [7:0] on_lat;
  logic [7:0] off_lat;
  logic [3:0] fault;
  logic [3:0] ack;
  logic [3:0] busy;

  int n_checks = 0;
  int n_err    = 0;
  int edge_cnt = 0;

  typedef struct {
    int         e;
    logic [3:0] mask;
    logic [3:0] ack;
    logic [3:0] busy;
    string      tag;
  } exp_t;

  exp_t sb[$];

  power_switch_ack_model #(.NUM_CH(4), .LAT_W(8), .RESET_ACK(4'b1111)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .switch_i (sw),
    .on_lat_i (on_lat),
    .off_lat_i(off_lat),
    .fault_i  (fault),
    .ack_o    (ack),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, expv, edge_cnt);
    end
  endtask

  // Keep the queue ordered by due edge so the monitor only ever looks at the front.
  task automatic push(input int e, input logic [3:0] m, input logic [3:0] a,
                      input logic [3:0] b, input string tag);
    exp_t it;
    int   pos;
    it.e = e; it.mask = m; it.ack = a; it.busy = b; it.tag = tag;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].e > e) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, it);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].e <= edge_cnt) begin
      exp_t it;
      it = sb.pop_front();
      chk({it.tag, "_ack"},  ack & it.mask,  it.ack & it.mask);
      chk({it.tag, "_busy"}, busy & it.mask, it.busy & it.mask);
    end
  end

  task automatic wait_to(input int e);
    @(negedge clk);
    while (edge_cnt < e) @(negedge clk);
  endtask

  initial begin
    int k;
    int ext;
    int guard;
`ifdef POWER_SWITCH_FAULT_INJ_EN
    ext = 5;
`else
    ext = 0;
`endif
    rst_n = 1'b0; sw = 4'b1111; on_lat = 8'd0; off_lat = 8'd0; fault = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 4'b1111);
    chk("rst_busy", busy, 4'b0000);
    rst_n = 1'b1;
    k = edge_cnt + 1;
    for (int i = 0; i < 20; i++) push(k + i, 4'b1111, 4'b1111, 4'b0000, "idle20");
    wait_to(k + 20);

    // Channel 0 off with 15 extra cycles, then back on with zero latency.
    off_lat = 8'd15; sw = 4'b1110; k = edge_cnt + 1;
    push(k,      4'b0001, 4'b0001, 4'b0001, "off15_start");
    push(k + 15, 4'b0001, 4'b0001, 4'b0001, "off15_hold");
    push(k + 16, 4'b0001, 4'b0000, 4'b0000, "off15_done");
    push(k + 16, 4'b1110, 4'b1110, 4'b0000, "off15_others");
    wait_to(k + 17);
    on_lat = 8'd0; sw = 4'b1111; k = edge_cnt + 1;
    push(k,     4'b0001, 4'b0000, 4'b0001, "on0_start");
    push(k + 1, 4'b1111, 4'b1111, 4'b0000, "on0_done");
    wait_to(k + 2);

    // Maximum latency on channel 1, then minimum.
    off_lat = 8'd255; on_lat = 8'd0; sw = 4'b1101; k = edge_cnt + 1;
    push(k + 255, 4'b0010, 4'b0010, 4'b0010, "off255_hold");
    push(k + 256, 4'b0010, 4'b0000, 4'b0000, "off255_done");
    wait_to(k + 257);
    sw = 4'b1111; k = edge_cnt + 1;
    push(k,     4'b0010, 4'b0000, 4'b0010, "on1_start");
    push(k + 1, 4'b1111, 4'b1111, 4'b0000, "on1_done");
    wait_to(k + 2);

    // Channel 2 request withdrawn four cycles in.
    off_lat = 8'd10; sw = 4'b1011; k = edge_cnt + 1;
    push(k,     4'b0100, 4'b0100, 4'b0100, "wd_start");
    push(k + 3, 4'b0100, 4'b0100, 4'b0100, "wd_ramp");
    wait_to(k + 3);
    sw = 4'b1111;
    push(k + 4,  4'b0100, 4'b0100, 4'b0000, "wd_abort");
    push(k + 11, 4'b0100, 4'b0100, 4'b0000, "wd_quiet");
    push(k + 15, 4'b1111, 4'b1111, 4'b0000, "wd_final");
    wait_to(k + 16);

    // All channels toggle together in both directions; latencies change mid-flight.
    off_lat = 8'd0; sw = 4'b1010; k = edge_cnt + 1;
    push(k,     4'b1111, 4'b1111, 4'b0101, "prep_start");
    push(k + 1, 4'b1111, 4'b1010, 4'b0000, "prep_done");
    wait_to(k + 2);
    on_lat = 8'd3; off_lat = 8'd7; sw = 4'b0101; k = edge_cnt + 1;
    push(k,     4'b1111, 4'b1010, 4'b1111, "all_start");
    push(k + 3, 4'b1111, 4'b1010, 4'b1111, "all_pre_on");
    push(k + 4, 4'b1111, 4'b1111, 4'b1010, "all_on");
    push(k + 7, 4'b1111, 4'b1111, 4'b1010, "all_pre_off");
    push(k + 8, 4'b1111, 4'b0101, 4'b0000, "all_off");
    wait_to(k + 1);
    on_lat = 8'd200; off_lat = 8'd200;
    wait_to(k + 9);

    // Channel 3 on-ramp with fault_i held for five sampling edges.
    on_lat = 8'd6; sw = 4'b1101; k = edge_cnt + 1;
    push(k,           4'b1000, 4'b0000, 4'b1000, "frz_start");
    push(k + 4,       4'b1000, 4'b0000, 4'b1000, "frz_mid");
    push(k + 6 + ext, 4'b1000, 4'b0000, 4'b1000, "frz_pre");
    push(k + 7 + ext, 4'b1000, 4'b1000, 4'b0000, "frz_done");
    wait_to(k + 1);
    fault = 4'b1000;
    wait_to(k + 6);
    fault = 4'b0000;
    wait_to(k + 8 + ext);

    // Reset mid-ramp on channel 3, then a fresh transition on channel 1 after release.
    off_lat = 8'd20; sw = 4'b0101; k = edge_cnt + 1;
    push(k, 4'b1000, 4'b1000, 4'b1000, "rr_start");
    wait_to(k + 5);
    #1 rst_n = 1'b0;
    #1;
    chk("rr_async_ack", ack, 4'b1111);
    chk("rr_async_busy", busy, 4'b0000);
    sw = 4'b1101; off_lat = 8'd4;
    @(negedge clk);
    rst_n = 1'b1; k = edge_cnt + 1;
    push(k,     4'b1111, 4'b1111, 4'b0010, "post_rst_start");
    push(k + 4, 4'b1111, 4'b1111, 4'b0010, "post_rst_hold");
    push(k + 5, 4'b1111, 4'b1101, 4'b0000, "post_rst_done");
    wait_to(k + 6);

    guard = 0;
    while (sb.size() > 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL drain: observed %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
